// File: rtl/load_buffer_pkg.sv
// Shared types, instruction codes and helpers for the load buffer.
package load_buffer_pkg;
    localparam int ROB_W  = 4;
    localparam int TYPE_W = 6;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic [ROB_W-1:0] NULL_TAG = '0;

    localparam logic [TYPE_W-1:0] LB  = 6'd1;
    localparam logic [TYPE_W-1:0] LH  = 6'd2;
    localparam logic [TYPE_W-1:0] LW  = 6'd3;
    localparam logic [TYPE_W-1:0] LBU = 6'd4;
    localparam logic [TYPE_W-1:0] LHU = 6'd5;
    localparam logic [TYPE_W-1:0] SB  = 6'd6;
    localparam logic [TYPE_W-1:0] SH  = 6'd7;
    localparam logic [TYPE_W-1:0] SW  = 6'd8;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } lb_state_t;

    typedef struct packed {
        logic [31:0]       addr;
        logic [ROB_W-1:0]  dest;
        logic [TYPE_W-1:0] itype;
    } load_entry_t;

    function automatic logic is_load(input logic [TYPE_W-1:0] t);
        return (t == LB) || (t == LH) || (t == LW) || (t == LBU) || (t == LHU);
    endfunction

    function automatic logic is_store(input logic [TYPE_W-1:0] t);
        return (t == SB) || (t == SH) || (t == SW);
    endfunction

    function automatic logic [1:0] mem_size(input logic [TYPE_W-1:0] t);
        if (t == LB || t == LBU) return MEM_BYTE;
        if (t == LH || t == LHU) return MEM_HALF;
        return MEM_WORD;
    endfunction
endpackage

// File: rtl/load_buffer_if.sv
// Issue, ROB, memory and CDB signals of the load buffer; slave = load buffer side.
interface load_buffer_if;
    import load_buffer_pkg::*;

    logic              rdy_in;
    logic              rob_flush_in;
    logic              lbuffer_rdy_out;
    logic              addressUnit_en_in;
    logic [31:0]       addressUnit_A_in;
    logic [31:0]       addressUnit_vj_in;
    logic [ROB_W-1:0]  addressUnit_dest_in;
    logic [TYPE_W-1:0] addressUnit_inst_type_in;
    logic              rob_store_pending_in;
    logic              rob_en_out;
    logic [ROB_W-1:0]  rob_dest_out;
    logic [31:0]       rob_addr_out;
    logic              mem_en_out;
    logic [31:0]       mem_addr_out;
    logic [1:0]        mem_size_out;
    logic              mem_done_in;
    logic [31:0]       mem_data_in;
    logic              cdb_en_out;
    logic [ROB_W-1:0]  cdb_dest_out;
    logic [31:0]       cdb_value_out;

    modport slave (
        input  rdy_in, rob_flush_in, addressUnit_en_in, addressUnit_A_in,
               addressUnit_vj_in, addressUnit_dest_in, addressUnit_inst_type_in,
               rob_store_pending_in, mem_done_in, mem_data_in,
        output lbuffer_rdy_out, rob_en_out, rob_dest_out, rob_addr_out,
               mem_en_out, mem_addr_out, mem_size_out,
               cdb_en_out, cdb_dest_out, cdb_value_out
    );

    modport master (
        output rdy_in, rob_flush_in, addressUnit_en_in, addressUnit_A_in,
               addressUnit_vj_in, addressUnit_dest_in, addressUnit_inst_type_in,
               rob_store_pending_in, mem_done_in, mem_data_in,
        input  lbuffer_rdy_out, rob_en_out, rob_dest_out, rob_addr_out,
               mem_en_out, mem_addr_out, mem_size_out,
               cdb_en_out, cdb_dest_out, cdb_value_out
    );
endinterface

// File: rtl/load_buffer_extend.sv
// load_extend: sign/zero extension of LSB-aligned read data by load type.
module load_extend
    import load_buffer_pkg::*;
(
    input  logic [TYPE_W-1:0] inst_type,
    input  logic [31:0]       data,
    output logic [31:0]       value
);
    always_comb begin
        value = data;
        case (inst_type)
            LB:      value = {{24{data[7]}}, data[7:0]};
            LBU:     value = {24'd0, data[7:0]};
            LH:      value = {{16{data[15]}}, data[15:0]};
            LHU:     value = {16'd0, data[15:0]};
            default: value = data;
        endcase
    end
endmodule

// File: rtl/load_buffer.sv
// Load buffer: address generation, load queue, memory read FSM and CDB broadcast.
// Optional LBUFFER_BYPASS_EN lets a load hit an idle, empty buffer skip the queue.
module load_buffer
    import load_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk_in,
    input  logic          rst_in,
    load_buffer_if.slave  lb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lb_state_t         state_reg, state_next;
    logic [PTR_W-1:0]  head_reg, head_next, tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    load_entry_t       queue_mem [DEPTH];
    logic [ROB_W-1:0]  inflight_dest_reg, inflight_dest_next;
    logic [TYPE_W-1:0] inflight_type_reg, inflight_type_next;
    logic              inflight_queued_reg, inflight_queued_next;

    logic              lbuffer_rdy_reg, lbuffer_rdy_next;
    logic              rob_en_reg, rob_en_next;
    logic [ROB_W-1:0]  rob_dest_reg, rob_dest_next;
    logic [31:0]       rob_addr_reg, rob_addr_next;
    logic              mem_en_reg, mem_en_next;
    logic [31:0]       mem_addr_reg, mem_addr_next;
    logic [1:0]        mem_size_reg, mem_size_next;
    logic              cdb_en_reg, cdb_en_next;
    logic [ROB_W-1:0]  cdb_dest_reg, cdb_dest_next;
    logic [31:0]       cdb_value_reg, cdb_value_next;

    logic [31:0]       issue_addr;
    logic              issue_load, issue_store, push, pop, bypass_taken;
    load_entry_t       head_entry, new_entry;
    logic [31:0]       ext_value;

    assign issue_addr  = lb.addressUnit_vj_in + lb.addressUnit_A_in;
    assign issue_load  = lb.addressUnit_en_in && is_load(lb.addressUnit_inst_type_in);
    assign issue_store = lb.addressUnit_en_in && is_store(lb.addressUnit_inst_type_in);
    assign new_entry   = '{addr: issue_addr, dest: lb.addressUnit_dest_in,
                           itype: lb.addressUnit_inst_type_in};
    // Head is read combinationally so a queued load can request on the very next edge.
    assign head_entry  = queue_mem[head_reg];

    load_extend u_extend (
        .inst_type (inflight_type_reg),
        .data      (lb.mem_data_in),
        .value     (ext_value)
    );

    always_comb begin
        state_next           = state_reg;
        head_next            = head_reg;
        tail_next            = tail_reg;
        count_next           = count_reg;
        inflight_dest_next   = inflight_dest_reg;
        inflight_type_next   = inflight_type_reg;
        inflight_queued_next = inflight_queued_reg;
        rob_en_next          = DISABLE;
        rob_dest_next        = rob_dest_reg;
        rob_addr_next        = rob_addr_reg;
        mem_en_next          = mem_en_reg;
        mem_addr_next        = mem_addr_reg;
        mem_size_next        = mem_size_reg;
        cdb_en_next          = DISABLE;
        cdb_dest_next        = cdb_dest_reg;
        cdb_value_next       = cdb_value_reg;
        push                 = 1'b0;
        pop                  = 1'b0;
        bypass_taken         = 1'b0;

        if (lb.rob_flush_in) begin
            head_next   = '0;
            tail_next   = '0;
            count_next  = '0;
            mem_en_next = DISABLE;
            // An outstanding read still owes us a done strobe; swallow it in DRAIN.
            if (state_reg == ST_WAIT) state_next = ST_DRAIN;
        end else begin
            if (issue_store) begin
                rob_en_next   = ENABLE;
                rob_dest_next = lb.addressUnit_dest_in;
                rob_addr_next = issue_addr;
            end

            case (state_reg)
                ST_IDLE: begin
`ifdef LBUFFER_BYPASS_EN
                    if (issue_load && count_reg == '0 && !lb.rob_store_pending_in) begin
                        bypass_taken         = 1'b1;
                        mem_en_next          = ENABLE;
                        mem_addr_next        = issue_addr;
                        mem_size_next        = mem_size(lb.addressUnit_inst_type_in);
                        inflight_dest_next   = lb.addressUnit_dest_in;
                        inflight_type_next   = lb.addressUnit_inst_type_in;
                        inflight_queued_next = 1'b0;
                        state_next           = ST_WAIT;
                    end
`endif
                    if (!bypass_taken && count_reg != '0 && !lb.rob_store_pending_in) begin
                        mem_en_next          = ENABLE;
                        mem_addr_next        = head_entry.addr;
                        mem_size_next        = mem_size(head_entry.itype);
                        inflight_dest_next   = head_entry.dest;
                        inflight_type_next   = head_entry.itype;
                        inflight_queued_next = 1'b1;
                        state_next           = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lb.mem_done_in) begin
                        mem_en_next    = DISABLE;
                        cdb_en_next    = ENABLE;
                        cdb_dest_next  = inflight_dest_reg;
                        cdb_value_next = ext_value;
                        pop            = inflight_queued_reg;
                        state_next     = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    mem_en_next = DISABLE;
                    if (lb.mem_done_in) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase

            push = issue_load && !bypass_taken && (count_reg != CNT_W'(DEPTH));
            if (push) tail_next = tail_reg + PTR_W'(1);
            if (pop)  head_next = head_reg + PTR_W'(1);
            if (push && !pop)      count_next = count_reg + CNT_W'(1);
            else if (pop && !push) count_next = count_reg - CNT_W'(1);
        end

        lbuffer_rdy_next = (CNT_W'(DEPTH) - count_next) >= CNT_W'(2);
    end

    always_ff @(posedge clk_in) begin
        if (lb.rdy_in && push) queue_mem[tail_reg] <= new_entry;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg           <= ST_IDLE;
            head_reg            <= '0;
            tail_reg            <= '0;
            count_reg           <= '0;
            inflight_dest_reg   <= NULL_TAG;
            inflight_type_reg   <= '0;
            inflight_queued_reg <= 1'b0;
            lbuffer_rdy_reg     <= DISABLE;
            rob_en_reg          <= DISABLE;
            rob_dest_reg        <= NULL_TAG;
            rob_addr_reg        <= '0;
            mem_en_reg          <= DISABLE;
            mem_addr_reg        <= '0;
            mem_size_reg        <= '0;
            cdb_en_reg          <= DISABLE;
            cdb_dest_reg        <= NULL_TAG;
            cdb_value_reg       <= '0;
        end else if (lb.rdy_in) begin
            state_reg           <= state_next;
            head_reg            <= head_next;
            tail_reg            <= tail_next;
            count_reg           <= count_next;
            inflight_dest_reg   <= inflight_dest_next;
            inflight_type_reg   <= inflight_type_next;
            inflight_queued_reg <= inflight_queued_next;
            lbuffer_rdy_reg     <= lbuffer_rdy_next;
            rob_en_reg          <= rob_en_next;
            rob_dest_reg        <= rob_dest_next;
            rob_addr_reg        <= rob_addr_next;
            mem_en_reg          <= mem_en_next;
            mem_addr_reg        <= mem_addr_next;
            mem_size_reg        <= mem_size_next;
            cdb_en_reg          <= cdb_en_next;
            cdb_dest_reg        <= cdb_dest_next;
            cdb_value_reg       <= cdb_value_next;
        end
    end

    assign lb.lbuffer_rdy_out = lbuffer_rdy_reg;
    assign lb.rob_en_out      = rob_en_reg;
    assign lb.rob_dest_out    = rob_dest_reg;
    assign lb.rob_addr_out    = rob_addr_reg;
    assign lb.mem_en_out      = mem_en_reg;
    assign lb.mem_addr_out    = mem_addr_reg;
    assign lb.mem_size_out    = mem_size_reg;
    assign lb.cdb_en_out      = cdb_en_reg;
    assign lb.cdb_dest_out    = cdb_dest_reg;
    assign lb.cdb_value_out   = cdb_value_reg;
endmodule

// File: tb/tb_load_buffer.sv
// Directed table-driven bench for load_buffer plus hand-written multi-cycle sequences.
module tb_load_buffer;
    import load_buffer_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    load_buffer_if bus ();

    load_buffer #(.DEPTH(8)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .lb     (bus.slave)
    );

    typedef struct {
        logic [TYPE_W-1:0] itype;
        logic [31:0]       vj;
        logic [31:0]       a;
        logic [ROB_W-1:0]  dest;
        logic [31:0]       data;
        logic [31:0]       exp_addr;
        logic [1:0]        exp_size;
        logic [31:0]       exp_value;
    } vec_t;

    vec_t vecs [9];
    int tests  = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_issue(input logic [TYPE_W-1:0] t, input logic [31:0] vj,
                             input logic [31:0] a, input logic [ROB_W-1:0] dest);
        bus.addressUnit_en_in        = 1'b1;
        bus.addressUnit_inst_type_in = t;
        bus.addressUnit_vj_in        = vj;
        bus.addressUnit_A_in         = a;
        bus.addressUnit_dest_in      = dest;
    endtask

    // Issue for one edge; the buffer must have advertised room beforehand.
    task automatic issue(input logic [TYPE_W-1:0] t, input logic [31:0] vj,
                         input logic [31:0] a, input logic [ROB_W-1:0] dest);
        chk("issue_allowed", {31'd0, bus.lbuffer_rdy_out}, 32'd1);
        set_issue(t, vj, a, dest);
        tick();
        bus.addressUnit_en_in = 1'b0;
    endtask

    task automatic wait_mem_en(input string name);
        int n = 0;
        while (!bus.mem_en_out && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'd0, bus.mem_en_out}, 32'd1);
    endtask

    task automatic complete(input string name, input logic [31:0] data,
                            input logic [ROB_W-1:0] exp_dest, input logic [31:0] exp_value);
        bus.mem_done_in = 1'b1;
        bus.mem_data_in = data;
        tick();
        bus.mem_done_in = 1'b0;
        $display("[TB] %s: cdb_en=%0d dest=%0d value=0x%08h", name,
                 bus.cdb_en_out, bus.cdb_dest_out, bus.cdb_value_out);
        chk({name, "_cdb_en"}, {31'd0, bus.cdb_en_out}, 32'd1);
        chk({name, "_cdb_dest"}, {28'd0, bus.cdb_dest_out}, {28'd0, exp_dest});
        chk({name, "_cdb_value"}, bus.cdb_value_out, exp_value);
        chk({name, "_mem_en_drop"}, {31'd0, bus.mem_en_out}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{LB,  32'h0000_1000, 32'hFFFF_FFFC, 4'd3,  32'h0000_0080, 32'h0000_0FFC, MEM_BYTE, 32'hFFFF_FF80};
        vecs[1] = '{SW,  32'h0000_0020, 32'h0000_0004, 4'd5,  32'h0,         32'h0000_0024, MEM_WORD, 32'h0};
        vecs[2] = '{LHU, 32'h0000_0200, 32'h0000_0010, 4'd6,  32'hABCD_8001, 32'h0000_0210, MEM_HALF, 32'h0000_8001};
        vecs[3] = '{LH,  32'h0000_0200, 32'h0000_0012, 4'd7,  32'hABCD_8001, 32'h0000_0212, MEM_HALF, 32'hFFFF_8001};
        vecs[4] = '{LW,  32'hFFFF_FFF0, 32'h0000_0020, 4'd8,  32'hDEAD_BEEF, 32'h0000_0010, MEM_WORD, 32'hDEAD_BEEF};
        vecs[5] = '{LBU, 32'h0000_0300, 32'h0000_0001, 4'd9,  32'h1234_5690, 32'h0000_0301, MEM_BYTE, 32'h0000_0090};
        vecs[6] = '{SB,  32'h0000_0100, 32'hFFFF_FFFF, 4'd10, 32'h0,         32'h0000_00FF, MEM_BYTE, 32'h0};
        vecs[7] = '{SH,  32'h0000_0000, 32'h0000_0008, 4'd11, 32'h0,         32'h0000_0008, MEM_HALF, 32'h0};
        vecs[8] = '{LB,  32'h0000_0040, 32'h0000_0000, 4'd12, 32'h0000_007F, 32'h0000_0040, MEM_BYTE, 32'h0000_007F};

        bus.rdy_in = 1'b1;
        bus.rob_flush_in = 1'b0;
        bus.addressUnit_en_in = 1'b0;
        bus.addressUnit_A_in = '0;
        bus.addressUnit_vj_in = '0;
        bus.addressUnit_dest_in = '0;
        bus.addressUnit_inst_type_in = '0;
        bus.rob_store_pending_in = 1'b0;
        bus.mem_done_in = 1'b0;
        bus.mem_data_in = '0;

        // Reset state
        tick();
        tick();
        chk("rst_lbuffer_rdy", {31'd0, bus.lbuffer_rdy_out}, 32'd0);
        chk("rst_mem_en", {31'd0, bus.mem_en_out}, 32'd0);
        chk("rst_cdb_en", {31'd0, bus.cdb_en_out}, 32'd0);
        chk("rst_rob_en", {31'd0, bus.rob_en_out}, 32'd0);
        rst_in = 1'b0;
        tick();
        chk("post_rst_lbuffer_rdy", {31'd0, bus.lbuffer_rdy_out}, 32'd1);

        // Table of single transactions
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].itype, vecs[i].vj, vecs[i].a, vecs[i].dest);
            if (is_store(vecs[i].itype)) begin
                $display("[TB] vec%0d store: rob_en=%0d dest=%0d addr=0x%08h", i,
                         bus.rob_en_out, bus.rob_dest_out, bus.rob_addr_out);
                chk("store_rob_en", {31'd0, bus.rob_en_out}, 32'd1);
                chk("store_rob_dest", {28'd0, bus.rob_dest_out}, {28'd0, vecs[i].dest});
                chk("store_rob_addr", bus.rob_addr_out, vecs[i].exp_addr);
                chk("store_no_mem_en", {31'd0, bus.mem_en_out}, 32'd0);
                tick();
                chk("store_rob_en_pulse", {31'd0, bus.rob_en_out}, 32'd0);
                chk("store_no_mem_en_late", {31'd0, bus.mem_en_out}, 32'd0);
            end else begin
`ifndef LBUFFER_BYPASS_EN
                chk("load_no_early_mem_en", {31'd0, bus.mem_en_out}, 32'd0);
`endif
                wait_mem_en("load_mem_en");
                chk("load_mem_addr", bus.mem_addr_out, vecs[i].exp_addr);
                chk("load_mem_size", {30'd0, bus.mem_size_out}, {30'd0, vecs[i].exp_size});
                complete($sformatf("vec%0d", i), vecs[i].data, vecs[i].dest, vecs[i].exp_value);
                tick();
                chk("load_cdb_pulse", {31'd0, bus.cdb_en_out}, 32'd0);
            end
        end

        // Seven loads with memory stalled: ready falls at count 7, then in-order completion
        for (int i = 1; i <= 7; i++) begin
            issue(LW, 32'h0000_1000, 32'(4 * i), 4'(i));
`ifndef LBUFFER_BYPASS_EN
            if (i == 6) chk("fill6_rdy", {31'd0, bus.lbuffer_rdy_out}, 32'd1);
            if (i == 7) chk("fill7_rdy", {31'd0, bus.lbuffer_rdy_out}, 32'd0);
`endif
        end
        for (int i = 1; i <= 7; i++) begin
            wait_mem_en("fill_mem_en");
            chk("fill_mem_addr", bus.mem_addr_out, 32'h0000_1000 + 32'(4 * i));
            complete($sformatf("fill%0d", i), 32'h0000_0100 + 32'(i), 4'(i), 32'h0000_0100 + 32'(i));
            if (i == 1) chk("fill_rdy_back", {31'd0, bus.lbuffer_rdy_out}, 32'd1);
        end
        tick();

        // Older store pending blocks the request until it clears
        bus.rob_store_pending_in = 1'b1;
        issue(LW, 32'h0000_0600, 32'h0000_0008, 4'd2);
        for (int i = 0; i < 5; i++) begin
            chk("pending_hold", {31'd0, bus.mem_en_out}, 32'd0);
            tick();
        end
        chk("pending_hold_last", {31'd0, bus.mem_en_out}, 32'd0);
        bus.rob_store_pending_in = 1'b0;
        tick();
        chk("pending_release_mem_en", {31'd0, bus.mem_en_out}, 32'd1);
        chk("pending_release_addr", bus.mem_addr_out, 32'h0000_0608);
        complete("pending", 32'hFFFF_0000, 4'd2, 32'hFFFF_0000);
        tick();

        // Flush while waiting: store issued in the flush cycle is dropped, late done is swallowed
        issue(LW, 32'h0000_0700, 32'h0000_0000, 4'd4);
        wait_mem_en("flush_mem_en");
        bus.rob_flush_in = 1'b1;
        set_issue(SW, 32'h0000_0010, 32'h0000_0000, 4'd6);
        tick();
        bus.rob_flush_in = 1'b0;
        bus.addressUnit_en_in = 1'b0;
        chk("flush_mem_en", {31'd0, bus.mem_en_out}, 32'd0);
        chk("flush_rob_en", {31'd0, bus.rob_en_out}, 32'd0);
        tick();
        tick();
        bus.mem_done_in = 1'b1;
        bus.mem_data_in = 32'h1111_1111;
        tick();
        bus.mem_done_in = 1'b0;
        chk("drain_no_cdb", {31'd0, bus.cdb_en_out}, 32'd0);
        tick();
        chk("drain_no_cdb_late", {31'd0, bus.cdb_en_out}, 32'd0);
        chk("drain_no_mem_en", {31'd0, bus.mem_en_out}, 32'd0);
        issue(LW, 32'h0000_0500, 32'h0000_0000, 4'd13);
        wait_mem_en("post_flush_mem_en");
        chk("post_flush_addr", bus.mem_addr_out, 32'h0000_0500);
        complete("post_flush", 32'h1122_3344, 4'd13, 32'h1122_3344);
        tick();

        // Store accept coinciding with load completion
        issue(LW, 32'h0000_0800, 32'h0000_0004, 4'd14);
        wait_mem_en("simul_mem_en");
        set_issue(SW, 32'h0000_0040, 32'h0000_0004, 4'd15);
        bus.mem_done_in = 1'b1;
        bus.mem_data_in = 32'hCAFE_F00D;
        tick();
        bus.addressUnit_en_in = 1'b0;
        bus.mem_done_in = 1'b0;
        $display("[TB] simul: cdb_en=%0d rob_en=%0d", bus.cdb_en_out, bus.rob_en_out);
        chk("simul_cdb_en", {31'd0, bus.cdb_en_out}, 32'd1);
        chk("simul_cdb_dest", {28'd0, bus.cdb_dest_out}, 32'd14);
        chk("simul_cdb_value", bus.cdb_value_out, 32'hCAFE_F00D);
        chk("simul_rob_en", {31'd0, bus.rob_en_out}, 32'd1);
        chk("simul_rob_dest", {28'd0, bus.rob_dest_out}, 32'd15);
        chk("simul_rob_addr", bus.rob_addr_out, 32'h0000_0044);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end
endmodule
